gated_pulse_bank: RTL and testbench
===================================

# gated_pulse_bank

Parametrised multi-channel successor to our single-gate AND clock-gating tile. Each channel generates its own registered square-wave pulse train from `clk`, controlled by an enable input. Enable changes take effect only at period boundaries, so a channel never emits a runt pulse. Each channel also counts its completed pulses, with one count selected for readout. The block sits between the `ui_in` control bits and the `uo_out` display/LED pins of a tile.

## Interface
- `CHANNELS`, default 2: number of independent channels; legal range 2..8.
- `DIV_W`, default 4: width of the half-period divider value.
- `CNT_W`, default 8: width of each per-channel pulse counter.

Ports:
- `clk`  in  1: single block clock; everything is on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `en`  in  CHANNELS: per-channel run request; level-sensitive, may be asynchronous to `clk`.
- `div`  in  DIV_W: shared half-period select; half-period = `div`+1 cycles.
- `sel`  in  $clog2(CHANNELS): channel whose count drives `cnt_out`.
- `clr`  in  1: synchronous clear of all counters and overflow flags.
- `gclk_out`  out  CHANNELS: registered pulse trains.
- `active`  out  CHANNELS: high while the channel state is not IDLE.
- `ovf`  out  CHANNELS: sticky counter-wrap flags.
- `cnt_out`  out  CNT_W: count of channel `sel`, combinational mux of registers.

## Operation
- Per channel: enable conditioner producing `en_s[i]`, see Configuration.
- Per channel: 3-state FSM (IDLE, HIGH, LOW) with DIV_W-bit phase counter `ph` and latched divider `dl`.
- IDLE: `gclk_out`=0, `ph`=0. If `en_s`=1: latch `dl`←`div`, go to HIGH.
- HIGH: `gclk_out`=1, `ph` increments each cycle.
  - When `ph`==`dl`: `ph`←0, go to LOW.
  - On that same HIGH→LOW edge, increment the pulse count.
- LOW: `gclk_out`=0, `ph` increments each cycle.
  - When `ph`==`dl` and `en_s`=1: latch `dl`←`div`, `ph`←0, go to HIGH.
  - When `ph`==`dl` and `en_s`=0: `ph`←0, go to IDLE.
- Deasserting `en` mid-HIGH completes the HIGH phase and the full LOW phase. No truncated pulse is ever produced.
- A `div` change mid-period is ignored until the next latch point.
- Period is 2×(`dl`+1) cycles at 50% duty. `div`=0 gives `clk`/2.
- Counter arithmetic is modulo 2^CNT_W. Wrap from all-ones to 0 sets `ovf[i]`, which holds until `clr` or `rst`.
- `clr` coinciding with an increment: `clr` wins; count becomes 0 and `ovf` is 0.
- `clr` does not affect FSM, `ph` or `gclk_out`.
- `sel` ≥ CHANNELS: `cnt_out`=0.

## Timing
- `rst` asserted forces, asynchronously: FSMs IDLE, `ph`/`dl`/counters/conditioner flops 0. All outputs 0 (`cnt_out`=0 follows).
- `rst` asserted mid-period truncates the output immediately; this is the only truncation allowed.
- After `rst` deasserts, the first FSM update is on the next rising edge.
- Enable latency, `en` first sampled high at edge E:
  - `gclk_out` rises after edge E+2 with the synchroniser.
  - `gclk_out` rises after edge E+1 without it.
- `active` follows FSM state with no extra delay and rises in the same cycle as `gclk_out`.
- Count updates on the edge where `gclk_out` falls. `cnt_out` reflects it in the same cycle.
- All channels are independent. Identical `en` timing yields phase-aligned outputs.

## Configuration
- `GATE_SYNC_EN` defined: each `en[i]` passes through a 2-flop synchroniser, reset to 0, so `en_s` is 2 edges late.
- Undefined: each `en[i]` is registered once, so `en_s` is 1 edge late; callers must supply `clk`-synchronous enables.
- No other behaviour differs between the two builds.

## Test plan
- Reset: hold `rst`=1 with `en`=all-ones → all outputs 0. Assert `rst` mid-HIGH → `gclk_out` drops to 0 without waiting for a clock edge.
- Basic run: `div`=2, `en[0]`=1 from edge 0, GATE_SYNC_EN defined:
  - `gclk_out[0]` high from edge 2, 3 cycles high / 3 low.
  - After 10 periods with `sel`=0, `cnt_out`=10.
- Clean stop: `div`=3, drop `en[0]` one cycle into HIGH → remaining 3 HIGH cycles plus 4 LOW cycles, then IDLE. `active[0]`=0 and count incremented exactly once.
- Divider change mid-period: `div` goes 1→4 during a HIGH phase → current period stays 2+2. The next period is 5+5.
- Wrap and clear:
  - CNT_W=4, run 16 pulses → count 0 and `ovf[0]`=1.
  - `clr` pulsed on an increment edge → count 0, `ovf[0]`=0.
- Independence: `en`=2'b11 with staggered starts, `div`=0 → each channel toggles every cycle. `sel` switching shows distinct counts. Repeat the whole plan without `GATE_SYNC_EN` and expect 1-edge latency.

Source files
------------

// File: rtl/gated_pulse_bank.sv
// gated_pulse_bank: per-channel enable-gated 50% square-wave generators with pulse counters.
// Build option GATE_SYNC_EN: 2-flop enable synchroniser (default: single register stage).
module gated_pulse_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         en,
  input  logic [DIV_W-1:0]            div,
  input  logic [$clog2(CHANNELS)-1:0] sel,
  input  logic                        clr,
  output logic [CHANNELS-1:0]         gclk_out,
  output logic [CHANNELS-1:0]         active,
  output logic [CHANNELS-1:0]         ovf,
  output logic [CNT_W-1:0]            cnt_out
);

  localparam int unsigned SEL_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t               state_q [CHANNELS];
  state_t               state_d [CHANNELS];
  logic [DIV_W-1:0]     ph_q    [CHANNELS];
  logic [DIV_W-1:0]     ph_d    [CHANNELS];
  logic [DIV_W-1:0]     dl_q    [CHANNELS];
  logic [DIV_W-1:0]     dl_d    [CHANNELS];
  logic [CNT_W-1:0]     cnt_q   [CHANNELS];
  logic [CNT_W-1:0]     cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]  ovf_d;
  logic [CHANNELS-1:0]  gclk_d;
  logic [CHANNELS-1:0]  active_d;
  logic [CHANNELS-1:0]  inc_c;
  logic [CHANNELS-1:0]  en_s;

`ifdef GATE_SYNC_EN
  logic [CHANNELS-1:0] en_meta;

  // Two-stage synchroniser for enables that may be asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_meta <= '0;
      en_s    <= '0;
    end else begin
      en_meta <= en;
      en_s    <= en_meta;
    end
  end
`else
  // Single register stage; enables are expected to be clk-synchronous
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s <= '0;
    end else begin
      en_s <= en;
    end
  end
`endif

  // State, phase, divider latch, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        state_q[i] <= IDLE;
        ph_q[i]    <= '0;
        dl_q[i]    <= '0;
        cnt_q[i]   <= '0;
      end
      gclk_out <= '0;
      active   <= '0;
      ovf      <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        state_q[i] <= state_d[i];
        ph_q[i]    <= ph_d[i];
        dl_q[i]    <= dl_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      gclk_out <= gclk_d;
      active   <= active_d;
      ovf      <= ovf_d;
    end
  end

  // Next-state: a period is only (re)started at a boundary, so no runt pulses
  always_comb begin
    gclk_d   = '0;
    active_d = '0;
    inc_c    = '0;
    ovf_d    = ovf;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      state_d[i] = state_q[i];
      ph_d[i]    = ph_q[i];
      dl_d[i]    = dl_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          ph_d[i] = '0;
          if (en_s[i]) begin
            dl_d[i]    = div;
            state_d[i] = HIGH;
          end
        end
        HIGH: begin
          if (ph_q[i] == dl_q[i]) begin
            ph_d[i]    = '0;
            state_d[i] = LOW;
            inc_c[i]   = 1'b1;
          end else begin
            ph_d[i] = ph_q[i] + DIV_W'(1);
          end
        end
        LOW: begin
          if (ph_q[i] == dl_q[i]) begin
            ph_d[i] = '0;
            if (en_s[i]) begin
              dl_d[i]    = div;
              state_d[i] = HIGH;
            end else begin
              state_d[i] = IDLE;
            end
          end else begin
            ph_d[i] = ph_q[i] + DIV_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          ph_d[i]    = '0;
        end
      endcase

      // Clear takes priority over a coincident increment
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc_c[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
        end
      end

      gclk_d[i]   = (state_d[i] == HIGH);
      active_d[i] = (state_d[i] != IDLE);
    end
  end

  // Readout mux; unmatched select values read as zero
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (sel == SEL_W'(i)) begin
        cnt_out = cnt_q[i];
      end
    end
  end

endmodule

// File: tb/tb_gated_pulse_bank.sv
// Scoreboard bench for gated_pulse_bank: a period-level reference model predicts every cycle.
`timescale 1ns/1ps
module tb_gated_pulse_bank;

  localparam int unsigned CH    = 3;
  localparam int unsigned DIV_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 2;
`ifdef GATE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     en  = '0;
  logic [DIV_W-1:0]  div = '0;
  logic [SEL_W-1:0]  sel = '0;
  logic              clr = 1'b0;
  logic [CH-1:0]     gclk_out;
  logic [CH-1:0]     active;
  logic [CH-1:0]     ovf;
  logic [CNT_W-1:0]  cnt_out;

  int n_chk  = 0;
  int n_fail = 0;

  gated_pulse_bank #(
    .CHANNELS(CH),
    .DIV_W   (DIV_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div     (div),
    .sel     (sel),
    .clr     (clr),
    .gclk_out(gclk_out),
    .active  (active),
    .ovf     (ovf),
    .cnt_out (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]            g;
    logic [CH-1:0]            a;
    logic [CH-1:0]            o;
    logic [CH-1:0][CNT_W-1:0] c;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each period is a block of 2*(div+1) cycles starting at an edge
  logic [CH-1:0] pipe [LAT];
  int  k;
  int  start [CH];
  int  half  [CH];
  bit  busy  [CH];
  int  mcnt  [CH];
  bit  movf  [CH];

  always @(posedge clk or posedge rst) begin
    exp_t          e;
    logic [CH-1:0] en_eff;
    bit            fall;
    if (rst) begin
      sb.delete();
      for (int j = 0; j < LAT; j++) pipe[j] = '0;
      for (int i = 0; i < int'(CH); i++) begin
        busy[i] = 1'b0;
        mcnt[i] = 0;
        movf[i] = 1'b0;
        start[i] = 0;
        half[i] = 1;
      end
      k = 0;
    end else begin
      en_eff = pipe[LAT-1];
      for (int j = LAT - 1; j > 0; j--) pipe[j] = pipe[j-1];
      pipe[0] = en;
      e = '0;
      for (int i = 0; i < int'(CH); i++) begin
        if (busy[i] && (k - start[i] >= 2 * half[i])) busy[i] = 1'b0;
        if (!busy[i] && en_eff[i]) begin
          busy[i]  = 1'b1;
          start[i] = k;
          half[i]  = int'(div) + 1;
        end
        fall = busy[i] && (k - start[i] == half[i]);
        if (clr) begin
          mcnt[i] = 0;
          movf[i] = 1'b0;
        end else if (fall) begin
          if (mcnt[i] == (1 << CNT_W) - 1) movf[i] = 1'b1;
          mcnt[i] = (mcnt[i] + 1) % (1 << CNT_W);
        end
        e.g[i] = busy[i] && (k - start[i] < half[i]);
        e.a[i] = busy[i];
        e.o[i] = movf[i];
        e.c[i] = CNT_W'(mcnt[i]);
      end
      k++;
      sb.push_back(e);
    end
  end

  // Monitor: one expected record per clock, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    int   s;
    logic [CNT_W-1:0] ec;
    if (rst) begin
      chk("rst_gclk",   32'(gclk_out), 32'(0));
      chk("rst_active", 32'(active),   32'(0));
      chk("rst_ovf",    32'(ovf),      32'(0));
      chk("rst_cnt",    32'(cnt_out),  32'(0));
    end else if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expected record at %0t", $time);
    end else begin
      e  = sb.pop_front();
      s  = int'(sel);
      ec = '0;
      if (s < int'(CH)) ec = e.c[s];
      chk("gclk_out", 32'(gclk_out), 32'(e.g));
      chk("active",   32'(active),   32'(e.a));
      chk("ovf",      32'(ovf),      32'(e.o));
      chk("cnt_out",  32'(cnt_out),  32'(ec));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_gclk(input int ch, input logic val, input int budget);
    bit found;
    found = 1'b0;
    for (int t = 0; t < budget && !found; t++) begin
      cyc(1);
      if (gclk_out[ch] === val) found = 1'b1;
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_gclk%0d: got timeout expected level %0b within %0d cycles", ch, val, budget);
    end
  endtask

  initial begin
    int b;
    // Reset held with all enables requested
    cyc(2);
    en = '1;
    cyc(4);
    en = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(2);

    // Basic run, div=2, more than 10 periods
    div = 4'd2;
    sel = 2'd0;
    en[0] = 1'b1;
    cyc(66);

    // Clean stop one cycle into HIGH with div=3
    div = 4'd3;
    wait_gclk(0, 1'b0, 20);
    wait_gclk(0, 1'b1, 20);
    cyc(1);
    en[0] = 1'b0;
    cyc(20);

    // Divider change during a HIGH phase
    div = 4'd1;
    en[0] = 1'b1;
    wait_gclk(0, 1'b1, 20);
    div = 4'd4;
    cyc(30);
    en[0] = 1'b0;
    cyc(20);

    // Wrap, then clear coinciding with increment edges
    div = 4'd0;
    en[0] = 1'b1;
    cyc(40);
    for (int r = 0; r < 4; r++) begin
      wait_gclk(0, 1'b1, 10);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      cyc(int'($urandom_range(3, 8)));
    end
    cyc(36);
    en[0] = 1'b0;
    cyc(6);

    // Independent channels with staggered starts, div=0, select sweep
    en[0] = 1'b1;
    cyc(3);
    en[1] = 1'b1;
    cyc(5);
    en[2] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = SEL_W'(s);
      cyc(4);
    end
    en = '0;
    cyc(10);

    // Randomised operation
    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(15, 0) == 0) begin
        b = int'($urandom_range(CH - 1, 0));
        en[b] = ~en[b];
      end
      if ($urandom_range(31, 0) == 0) div = DIV_W'($urandom_range(15, 0));
      if ($urandom_range(7, 0) == 0) sel = SEL_W'($urandom_range(3, 0));
      clr = ($urandom_range(63, 0) == 0);
      cyc(1);
    end
    clr = 1'b0;
    en = '0;
    cyc(40);

    // Asynchronous reset in the middle of a HIGH phase
    div = 4'd3;
    en[1] = 1'b1;
    wait_gclk(1, 1'b1, 20);
    cyc(1);
    rst = 1'b1;
    #1;
    chk("async_rst_gclk",   32'(gclk_out), 32'(0));
    chk("async_rst_active", 32'(active),   32'(0));
    cyc(3);
    en = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(3);
    en = 3'b101;
    div = 4'd1;
    cyc(30);
    en = '0;
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
